traffic_monitor: RTL
====================

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 SHALL have parameter GREEN_CYC, default 8, required green length in clk cycles (range 1..255).
REQ-002 SHALL have parameter YELLOW_CYC, default 4, required yellow length in clk cycles (range 1..255).
REQ-003 SHALL have parameter MAX_GAP, default 2, maximum all-off cycles allowed between approaches (range 0..254).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports ng ny sg sy eg ey wg wy  input  1 each  green/yellow lamp drives for north/south/east/west.
REQ-007 SHALL have port fault_clr  input  1  clears a latched fault, synchronous.
REQ-008 SHALL have port fault  output  1  latched violation flag.
REQ-009 SHALL have port fault_code  output  3  violation cause; 0 when fault low.
REQ-010 SHALL have port fault_dir  output  2  approach implicated (N=0, S=1, E=2, W=3).
REQ-011 SHALL have port flash_req  output  1  all-red flash request to signal heads; equals fault.
REQ-012 SHALL have port phase_dir  output  2  approach currently tracked.
REQ-013 SHALL have port rotations  output  8  count of completed N-S-E-W rotations.

Function
REQ-014 SHALL sample all lamp inputs each rising edge; any fault SHALL appear on outputs the cycle after the offending sample.
REQ-015 SHALL implement states SYNC, GREEN, YELLOW, GAP, FAULT.
REQ-016 SYNC: all lamps off -> stay; single approach green only -> GREEN, phase_dir = that approach, green count = 1.
REQ-017 GREEN: same green held -> count+1; count reaching GREEN_CYC+1 -> code 3 GREEN_TIME.
REQ-018 GREEN: transition to same-approach yellow only -> YELLOW if count == GREEN_CYC, else code 3.
REQ-019 GREEN: any other lamp pattern -> code 2 SEQUENCE.
REQ-020 YELLOW: yellow held -> count+1; count reaching YELLOW_CYC+1 -> code 4 YELLOW_TIME.
REQ-021 YELLOW: all off -> GAP if count == YELLOW_CYC, else code 4; direct green of next approach is permitted only when MAX_GAP == 0.
REQ-022 GAP: all off -> gap count+1; gap count reaching MAX_GAP+1 -> code 5 GAP_TIMEOUT.
REQ-023 GAP: green of next approach (N->S->E->W->N) -> GREEN; green of any other approach -> code 2.
REQ-024 Any state: yellow sampled while the same approach was not green on the previous sample -> code 6 YELLOW_NO_GREEN.
REQ-025 Any state: more than one lamp high (two approaches, or G and Y of one approach) -> code 1 CONFLICT.
REQ-026 Simultaneous violations SHALL report the lowest code; fault_dir SHALL be the lowest-numbered approach involved.
REQ-027 FAULT: fault, code and dir frozen; all checking suspended until rst or fault_clr.
REQ-028 fault_clr in FAULT -> SYNC next cycle with fault low; fault_clr in other states SHALL be ignored.
REQ-029 rotations SHALL increment when W yellow completes legally; it SHALL wrap 255 -> 0.

Reset
REQ-030 rst SHALL force state SYNC, fault 0, fault_code 0, fault_dir 0, flash_req 0, phase_dir 0, rotations 0, all counters 0.
REQ-031 rst SHALL take priority over fault_clr and all lamp inputs, including mid-phase.

Configuration
REQ-032 With macro TRAFFIC_MON_GAP_CHECK_EN defined, REQ-022 timeout SHALL be active.
REQ-033 Without TRAFFIC_MON_GAP_CHECK_EN, GAP SHALL last indefinitely, code 5 SHALL never be produced, and MAX_GAP SHALL only gate REQ-021 direct green.

Verification
REQ-034 Legal sequence N,S,E,W each 8G/4Y/2 off, repeated 256 times -> fault 0 throughout, rotations wraps to 0.
REQ-035 ng and eg high same cycle during N green -> next cycle fault 1, code 1, dir 0, flash_req 1.
REQ-036 N green 7 cycles then ny -> fault code 3, dir 0; then fault_clr 1 cycle -> fault 0, state SYNC.
REQ-037 After N yellow completes, eg rises (S skipped) -> fault code 2, dir 2.
REQ-038 All off 3 cycles after S yellow, macro defined -> code 5 dir 1; macro undefined -> no fault, then eg accepted.
REQ-039 sy asserted with sg never high -> code 6, dir 1; rst mid-fault -> all outputs 0 next cycle.

Source files
------------

// File: rtl/traffic_monitor.sv
// traffic_monitor: watches the eight green/yellow lamp drives of a four-approach
// intersection and latches the first sequencing or timing violation it sees.
// Legal cycle per approach: GREEN_CYC greens, YELLOW_CYC yellows, then at most
// MAX_GAP all-off cycles before the next approach (N->S->E->W->N) turns green.
//
// Optional build macro: TRAFFIC_MON_GAP_CHECK_EN enables the all-off gap timeout
// (code 5). Without it the gap may last indefinitely.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ng..wy                lamp drives (green/yellow per approach)
//   fault_clr             clears a latched fault (only honoured while faulted)
//   fault, flash_req      latched violation flag / all-red flash request
//   fault_code, fault_dir violation cause (0 when no fault) and approach implicated
//   phase_dir             approach currently tracked (N=0, S=1, E=2, W=3)
//   rotations             completed N-S-E-W rotations, wraps at 256
module traffic_monitor #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned MAX_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ng,
    input  logic       ny,
    input  logic       sg,
    input  logic       sy,
    input  logic       eg,
    input  logic       ey,
    input  logic       wg,
    input  logic       wy,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic       flash_req,
    output logic [1:0] phase_dir,
    output logic [7:0] rotations
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_CYC);
    localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_CYC);
`ifdef TRAFFIC_MON_GAP_CHECK_EN
    localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(MAX_GAP);
`endif
    // Yellow straight into the next green is only legal when no gap is allowed
    localparam bit DIRECT_OK = (MAX_GAP == 0);

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_SEQ      = 3'd2;
    localparam logic [2:0] C_GREEN    = 3'd3;
    localparam logic [2:0] C_YELLOW   = 3'd4;
    localparam logic [2:0] C_GAP      = 3'd5;
    localparam logic [2:0] C_YNG      = 3'd6;

    typedef enum logic [2:0] {S_SYNC, S_GREEN, S_YELLOW, S_GAP, S_FAULT} state_e;

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [7:0]       rot_q, rot_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic [1:0]       fdir_q, fdir_d;
    logic [3:0]       prev_g_q, prev_y_q;

    logic [3:0] g, y, lit, yng;
    logic [7:0] lamps;
    logic       any_lit, multi, single;
    logic [1:0] lit_dir, next_dir;
    logic [2:0] seq_code, viol_code;
    logic [1:0] seq_dir, viol_dir;
    logic       yellow_done;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        if (v[0])      lowest = 2'd0;
        else if (v[1]) lowest = 2'd1;
        else if (v[2]) lowest = 2'd2;
        else           lowest = 2'd3;
    endfunction

    // Lamp decode: indices follow the approach numbering N, S, E, W
    assign g        = {wg, eg, sg, ng};
    assign y        = {wy, ey, sy, ny};
    assign lit      = g | y;
    assign lamps    = {y, g};
    assign any_lit  = |lamps;
    assign multi    = (lamps & (lamps - 8'd1)) != 8'd0;
    assign single   = any_lit & ~multi;
    assign lit_dir  = lowest(lit);
    assign next_dir = phase_q + 2'd1;
    // Yellow onset without the same approach being green or yellow just before
    assign yng      = y & ~prev_y_q & ~prev_g_q;

    // Next-state, counters and violation resolution
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        rot_d       = rot_q;
        fault_d     = fault_q;
        code_d      = code_q;
        fdir_d      = fdir_q;
        seq_code    = C_NONE;
        seq_dir     = phase_q;
        viol_code   = C_NONE;
        viol_dir    = 2'd0;
        yellow_done = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (single && (|g)) begin
                    state_d = S_GREEN;
                    phase_d = lit_dir;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_GREEN: begin
                if (single && g[phase_q]) begin
                    if (cnt_q == GREEN_LIM) seq_code = C_GREEN;
                    else                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (single && y[phase_q]) begin
                    if (cnt_q == GREEN_LIM) begin
                        state_d = S_YELLOW;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        seq_code = C_GREEN;
                    end
                end else begin
                    seq_code = C_SEQ;
                    seq_dir  = any_lit ? lit_dir : phase_q;
                end
            end
            S_YELLOW: begin
                if (single && y[phase_q]) begin
                    if (cnt_q == YELLOW_LIM) seq_code = C_YELLOW;
                    else                     cnt_d    = cnt_q + CNT_W'(1);
                end else if (!any_lit) begin
                    if (cnt_q == YELLOW_LIM) begin
                        state_d     = S_GAP;
                        cnt_d       = '0;
                        gap_d       = CNT_W'(1);
                        yellow_done = 1'b1;
`ifdef TRAFFIC_MON_GAP_CHECK_EN
                        // With no gap allowed, the first dark cycle is already late
                        if (GAP_LIM == '0) seq_code = C_GAP;
`endif
                    end else begin
                        seq_code = C_YELLOW;
                    end
                end else if (single && g[next_dir] && DIRECT_OK) begin
                    if (cnt_q == YELLOW_LIM) begin
                        state_d     = S_GREEN;
                        phase_d     = next_dir;
                        cnt_d       = CNT_W'(1);
                        yellow_done = 1'b1;
                    end else begin
                        seq_code = C_YELLOW;
                    end
                end else begin
                    seq_code = C_SEQ;
                    seq_dir  = lit_dir;
                end
            end
            S_GAP: begin
                if (!any_lit) begin
`ifdef TRAFFIC_MON_GAP_CHECK_EN
                    if (gap_q == GAP_LIM) seq_code = C_GAP;
                    else                  gap_d    = gap_q + CNT_W'(1);
`else
                    if (gap_q != '1) gap_d = gap_q + CNT_W'(1);
`endif
                end else if (single && g[next_dir]) begin
                    state_d = S_GREEN;
                    phase_d = next_dir;
                    cnt_d   = CNT_W'(1);
                    gap_d   = '0;
                end else begin
                    seq_code = C_SEQ;
                    seq_dir  = lit_dir;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_SYNC;
                    fault_d = 1'b0;
                    code_d  = C_NONE;
                    fdir_d  = 2'd0;
                    cnt_d   = '0;
                    gap_d   = '0;
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (yellow_done && (phase_q == 2'd3)) rot_d = rot_q + 8'd1;

        // Lowest code wins: conflict, then state-specific code (2..5), then yellow onset
        viol_code = seq_code;
        viol_dir  = seq_dir;
        if ((viol_code == C_NONE) && (|yng)) begin
            viol_code = C_YNG;
            viol_dir  = lowest(yng);
        end
        if (multi) begin
            viol_code = C_CONFLICT;
            viol_dir  = lit_dir;
        end

        if ((state_q != S_FAULT) && (viol_code != C_NONE)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            code_d  = viol_code;
            fdir_d  = viol_dir;
            phase_d = phase_q;
            cnt_d   = cnt_q;
            gap_d   = gap_q;
            rot_d   = rot_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SYNC;
            phase_q  <= 2'd0;
            cnt_q    <= '0;
            gap_q    <= '0;
            rot_q    <= 8'd0;
            fault_q  <= 1'b0;
            code_q   <= C_NONE;
            fdir_q   <= 2'd0;
            prev_g_q <= 4'd0;
            prev_y_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            rot_q    <= rot_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            fdir_q   <= fdir_d;
            prev_g_q <= g;
            prev_y_q <= y;
        end
    end

    assign fault      = fault_q;
    assign flash_req  = fault_q;
    assign fault_code = code_q;
    assign fault_dir  = fdir_q;
    assign phase_dir  = phase_q;
    assign rotations  = rot_q;

endmodule
